// File: rtl/rab_miss_replay_ctrl.sv
// rab_miss_replay_ctrl
// Sequences the head entry of a RAB BRAM transaction buffer. The head is held
// while a translation lookup runs; hits are forwarded downstream, misses are
// parked until the miss handler replays or drops them. Entries the handler
// never serves are auto-dropped after TIMEOUT miss cycles, and a flush command
// drains every pending entry.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   buf_valid_i, buf_data_i     buffer head entry
//   buf_ready_o                 pop strobe back to the buffer
//   lookup_req_o/addr_o         one-cycle lookup request and its address
//   lookup_valid_i/hit_i        lookup result strobe and hit/miss flag
//   out_valid_o/data_o/ready_i  downstream handshake
//   miss_o, miss_addr_o         parked-miss indication and captured address
//   handler_valid_i/replay_i    miss handler decision (1=replay, 0=drop)
//   flush_i                     drain all pending entries
//   timeout_o                   sticky flag, set on any auto-drop
//   drop_cnt_o                  saturating count of dropped entries
//
// ADDR_WIDTH must not exceed DATA_WIDTH; TIMEOUT must be at least 2.

module rab_miss_replay_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_valid_i,
    input  logic [DATA_WIDTH-1:0] buf_data_i,
    output logic                  buf_ready_o,
    output logic                  lookup_req_o,
    output logic [ADDR_WIDTH-1:0] lookup_addr_o,
    input  logic                  lookup_valid_i,
    input  logic                  lookup_hit_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic                  miss_o,
    output logic [ADDR_WIDTH-1:0] miss_addr_o,
    input  logic                  handler_valid_i,
    input  logic                  handler_replay_i,
    input  logic                  flush_i,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FWD,
        MISS,
        DROP,
        FLUSH
    } state_t;

    state_t        state;
    state_t        next;
    logic [TW-1:0] miss_cnt;
    logic          lookup_phase;
    logic          got_hit;
    logic          got_miss;
    logic          timed_out;
    logic          drop_pop;

    // A result strobe only counts while a lookup is actually outstanding.
    assign lookup_phase = (state == REQ) || (state == WAIT);
    assign got_hit      = lookup_phase && lookup_valid_i && lookup_hit_i;
    assign got_miss     = lookup_phase && lookup_valid_i && !lookup_hit_i;

    // Handler and flush both outrank the timeout in the final miss cycle.
    assign timed_out = (state == MISS) && !handler_valid_i && !flush_i &&
                       (miss_cnt == CNT_LAST);

    assign drop_pop = buf_ready_o && ((state == DROP) || (state == FLUSH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  if (buf_valid_i) next = REQ;
            REQ, WAIT: begin
                if (got_hit)              next = FWD;
                else if (got_miss)        next = MISS;
                else                      next = WAIT;
            end
            FWD:   if (out_ready_i) next = IDLE;
            MISS: begin
                if (handler_valid_i)      next = handler_replay_i ? REQ : DROP;
                else if (flush_i)         next = FLUSH;
                else if (timed_out)       next = DROP;
            end
            DROP:  next = IDLE;
            FLUSH: if (!buf_valid_i) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        lookup_req_o = 1'b0;
        out_valid_o  = 1'b0;
        miss_o       = 1'b0;
        buf_ready_o  = 1'b0;
        case (state)
            REQ:         lookup_req_o = 1'b1;
            FWD: begin
                out_valid_o = 1'b1;
                buf_ready_o = out_ready_i && buf_valid_i;
            end
            MISS:        miss_o = 1'b1;
            DROP, FLUSH: buf_ready_o = buf_valid_i;
            default: ;
        endcase
    end

    // Address/data are gated so every output reads zero outside its phase,
    // including while reset is held.
    assign lookup_addr_o = lookup_req_o ? buf_data_i[ADDR_WIDTH-1:0] : '0;
    assign out_data_o    = out_valid_o ? buf_data_i : '0;

    // The miss counter is zero on the first MISS cycle and counts up from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
        end else if (state != MISS) begin
            miss_cnt <= '0;
        end else begin
            miss_cnt <= miss_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr_o <= '0;
            timeout_o   <= 1'b0;
            drop_cnt_o  <= '0;
        end else begin
            if (got_miss) begin
                miss_addr_o <= buf_data_i[ADDR_WIDTH-1:0];
            end
            if (timed_out) begin
                timeout_o <= 1'b1;
            end
            if (drop_pop && (drop_cnt_o != {CNT_WIDTH{1'b1}})) begin
                drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rab_miss_replay_ctrl.sv
// Testbench for rab_miss_replay_ctrl (TIMEOUT=8, 3-bit drop counter so that
// saturation is reachable). Each vector drives one clock cycle of inputs and
// lists the outputs expected during that cycle; forwarded data is checked
// against a scoreboard filled whenever a hit result is driven.

module tb_rab_miss_replay_ctrl;

    localparam int CW = 3;

    typedef struct {
        logic          rst;
        logic          bv;
        logic [31:0]   data;
        logic          lv;
        logic          lh;
        logic          ordy;
        logic          hv;
        logic          hr;
        logic          fl;
        logic          e_br;
        logic          e_req;
        logic          e_ov;
        logic          e_miss;
        logic          e_to;
        logic [CW-1:0] e_drop;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          buf_valid_i;
    logic [31:0]   buf_data_i;
    logic          buf_ready_o;
    logic          lookup_req_o;
    logic [31:0]   lookup_addr_o;
    logic          lookup_valid_i;
    logic          lookup_hit_i;
    logic          out_valid_o;
    logic [31:0]   out_data_o;
    logic          out_ready_i;
    logic          miss_o;
    logic [31:0]   miss_addr_o;
    logic          handler_valid_i;
    logic          handler_replay_i;
    logic          flush_i;
    logic          timeout_o;
    logic [CW-1:0] drop_cnt_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            vec_idx  = 0;
    logic [31:0]   exp_maddr = '0;
    logic [31:0]   sb[$];
    vec_t          tbl[$];

    rab_miss_replay_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT(8),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buf_valid_i(buf_valid_i),
        .buf_data_i(buf_data_i),
        .buf_ready_o(buf_ready_o),
        .lookup_req_o(lookup_req_o),
        .lookup_addr_o(lookup_addr_o),
        .lookup_valid_i(lookup_valid_i),
        .lookup_hit_i(lookup_hit_i),
        .out_valid_o(out_valid_o),
        .out_data_o(out_data_o),
        .out_ready_i(out_ready_i),
        .miss_o(miss_o),
        .miss_addr_o(miss_addr_o),
        .handler_valid_i(handler_valid_i),
        .handler_replay_i(handler_replay_i),
        .flush_i(flush_i),
        .timeout_o(timeout_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic bv, input logic [31:0] d,
                                input logic lv, input logic lh, input logic ordy,
                                input logic hv, input logic hr, input logic fl,
                                input logic e_br, input logic e_req, input logic e_ov,
                                input logic e_miss, input logic e_to,
                                input logic [CW-1:0] e_drop);
        vec_t v;
        v.rst = r;      v.bv = bv;      v.data = d;
        v.lv = lv;      v.lh = lh;      v.ordy = ordy;
        v.hv = hv;      v.hr = hr;      v.fl = fl;
        v.e_br = e_br;  v.e_req = e_req; v.e_ov = e_ov;
        v.e_miss = e_miss; v.e_to = e_to; v.e_drop = e_drop;
        return v;
    endfunction

    // Inputs change just after the falling edge, well clear of the active edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        buf_valid_i      = v.bv;
        buf_data_i       = v.data;
        lookup_valid_i   = v.lv;
        lookup_hit_i     = v.lh;
        out_ready_i      = v.ordy;
        handler_valid_i  = v.hv;
        handler_replay_i = v.hr;
        flush_i          = v.fl;
        if (v.rst) begin
            exp_maddr = '0;
            sb.delete();
        end else if (v.lv && v.lh) begin
            sb.push_back(v.data);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, expected 0x%0h",
                     name, vec_idx, act, exp);
        end
    endtask

    task automatic runVector(input vec_t v);
        logic [31:0] exp_data;
        applyStimulus(v);
        #1;
        checkOutput("buf_ready",  32'(buf_ready_o),  32'(v.e_br));
        checkOutput("lookup_req", 32'(lookup_req_o), 32'(v.e_req));
        checkOutput("out_valid",  32'(out_valid_o),  32'(v.e_ov));
        checkOutput("miss",       32'(miss_o),       32'(v.e_miss));
        checkOutput("timeout",    32'(timeout_o),    32'(v.e_to));
        checkOutput("drop_cnt",   32'(drop_cnt_o),   32'(v.e_drop));
        checkOutput("miss_addr",  miss_addr_o,       exp_maddr);
        if (v.e_req) begin
            checkOutput("lookup_addr", lookup_addr_o, v.data);
        end
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_fwd (vector %0d): got data 0x%0h, expected no forward",
                         vec_idx, out_data_o);
            end else begin
                exp_data = sb.pop_front();
                checkOutput("out_data", out_data_o, exp_data);
            end
        end
        if (!v.rst && v.lv && !v.lh) begin
            exp_maddr = v.data;
        end
        vec_idx++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] h;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] x;
        h = 32'h0000_1234;
        b = 32'h5555_AAAA;
        r = 32'hABCD_0000;
        x = 32'h0BAD_F00D;

        rst = 1'b1;
        buf_valid_i = 1'b0;  buf_data_i = '0;
        lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; out_ready_i = 1'b0;
        handler_valid_i = 1'b0; handler_replay_i = 1'b0; flush_i = 1'b0;

        // reset held, then released: everything reads zero
        tbl.push_back(mk(1,0,'0,0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,h, 1,1,1,1,1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,'0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // hit path, zero-latency lookup
        tbl.push_back(mk(0,1,h, 0,0,1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,h, 1,1,1,0,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(0,1,h, 0,0,1,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,'0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // backpressure: five stalled cycles, pop on the sixth
        tbl.push_back(mk(0,1,b, 0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,b, 1,1,0,0,0,0, 0,1,0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,1,b, 0,0,0,0,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,1,b, 0,0,1,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,'0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // miss in WAIT, replay (handler beats flush), then hit
        tbl.push_back(mk(0,1,r, 0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,r, 0,0,0,0,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(0,1,r, 1,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,r, 0,0,1,1,1,1, 0,0,0,1,0,0));
        tbl.push_back(mk(0,1,r, 1,1,0,0,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(0,1,r, 0,0,1,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,'0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // miss then handler drop
        tbl.push_back(mk(0,1,x, 0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,x, 1,0,1,0,0,0, 0,1,0,0,0,0));
        tbl.push_back(mk(0,1,x, 0,0,1,1,0,0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,1,x, 0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,'0,0,0,0,0,0,0, 0,0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) runVector(tbl[i]);

        // timeout: eight MISS cycles then auto-drop, timeout sticky
        runVector(mk(0,1,32'h7777_0001, 0,0,0,0,0,0, 0,0,0,0,0,1));
        runVector(mk(0,1,32'h7777_0001, 1,0,0,0,0,0, 0,1,0,0,0,1));
        for (int i = 0; i < 8; i++)
            runVector(mk(0,1,32'h7777_0001, 0,0,0,0,0,0, 0,0,0,1,0,1));
        runVector(mk(0,1,32'h7777_0001, 0,0,0,0,0,0, 1,0,0,0,1,1));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,1,2));

        // handler strobe in the final MISS cycle wins over the timeout
        runVector(mk(0,1,32'h7777_0002, 0,0,0,0,0,0, 0,0,0,0,1,2));
        runVector(mk(0,1,32'h7777_0002, 1,0,0,0,0,0, 0,1,0,0,1,2));
        for (int i = 0; i < 7; i++)
            runVector(mk(0,1,32'h7777_0002, 0,0,0,0,0,0, 0,0,0,1,1,2));
        runVector(mk(0,1,32'h7777_0002, 0,0,0,1,1,0, 0,0,0,1,1,2));
        runVector(mk(0,1,32'h7777_0002, 1,1,1,0,0,0, 0,1,0,0,1,2));
        runVector(mk(0,1,32'h7777_0002, 0,0,1,0,0,0, 1,0,1,0,1,2));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,1,2));

        // flush of three buffered entries
        runVector(mk(0,1,32'hE000_0000, 0,0,0,0,0,0, 0,0,0,0,1,2));
        runVector(mk(0,1,32'hE000_0000, 1,0,0,0,0,0, 0,1,0,0,1,2));
        runVector(mk(0,1,32'hE000_0000, 0,0,0,0,0,1, 0,0,0,1,1,2));
        runVector(mk(0,1,32'hE000_0000, 0,0,0,0,0,0, 1,0,0,0,1,2));
        runVector(mk(0,1,32'hE000_0001, 0,0,0,0,0,0, 1,0,0,0,1,3));
        runVector(mk(0,1,32'hE000_0002, 0,0,0,0,0,0, 1,0,0,0,1,4));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,1,5));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,1,5));

        // reset during FLUSH: no further pops, head looked up again afterwards
        runVector(mk(0,1,32'hF000_0000, 0,0,0,0,0,0, 0,0,0,0,1,5));
        runVector(mk(0,1,32'hF000_0000, 1,0,0,0,0,0, 0,1,0,0,1,5));
        runVector(mk(0,1,32'hF000_0000, 0,0,0,0,0,1, 0,0,0,1,1,5));
        runVector(mk(0,1,32'hF000_0000, 0,0,0,0,0,0, 1,0,0,0,1,5));
        runVector(mk(1,1,32'hF000_0001, 0,0,0,0,0,0, 0,0,0,0,0,0));
        runVector(mk(1,1,32'hF000_0001, 0,0,0,0,0,0, 0,0,0,0,0,0));
        runVector(mk(0,1,32'hF000_0001, 0,0,0,0,0,0, 0,0,0,0,0,0));
        runVector(mk(0,1,32'hF000_0001, 1,1,1,0,0,0, 0,1,0,0,0,0));
        runVector(mk(0,1,32'hF000_0001, 0,0,1,0,0,0, 1,0,1,0,0,0));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,0,0));

        // drop counter saturates at all-ones during a long flush
        runVector(mk(0,1,32'h5A00_0000, 0,0,0,0,0,0, 0,0,0,0,0,0));
        runVector(mk(0,1,32'h5A00_0000, 1,0,0,0,0,0, 0,1,0,0,0,0));
        runVector(mk(0,1,32'h5A00_0000, 0,0,0,0,0,1, 0,0,0,1,0,0));
        for (int i = 0; i < 9; i++)
            runVector(mk(0,1,32'h5A00_0000 + 32'(i), 0,0,0,0,0,0, 1,0,0,0,0,
                         (i > 7) ? CW'(7) : CW'(i)));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,0,7));
        runVector(mk(0,0,'0, 0,0,0,0,0,0, 0,0,0,0,0,7));

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
